// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if
//   Bundles the gate_sequencer handshake and datapath signals.
//   master : upstream loader + multiplier/gate bank side (drives init/cmd/mult_out/res_ready)
//   slave  : gate_sequencer side
//   Vector layout (V = 2*W*2**N): element k real [(2k)*W +: W], imag [(2k+1)*W +: W].
interface gate_sequencer_if #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int GID_W = 4
);
    localparam int MAX = 2 ** N;
    localparam int V   = 2 * W * MAX;

    logic             init_valid;
    logic             init_ready;
    logic [V-1:0]     init_state;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [GID_W-1:0] cmd_gid;
    logic             cmd_last;
    logic [GID_W-1:0] gate_sel;
    logic [V-1:0]     mult_state;
    logic [V-1:0]     mult_out;
    logic             res_valid;
    logic             res_ready;
    logic [V-1:0]     res_state;
    logic             busy;
    logic [7:0]       gate_count;

    modport master (
        output init_valid, init_state, cmd_valid, cmd_gid, cmd_last, mult_out, res_ready,
        input  init_ready, cmd_ready, gate_sel, mult_state, res_valid, res_state, busy, gate_count
    );

    modport slave (
        input  init_valid, init_state, cmd_valid, cmd_gid, cmd_last, mult_out, res_ready,
        output init_ready, cmd_ready, gate_sel, mult_state, res_valid, res_state, busy, gate_count
    );
endinterface

// File: rtl/gate_sequencer.sv
// gate_sequencer
//   Applies a queued program of gate IDs to a state vector through an external
//   gate bank / multiplier. Each gate: present gate_sel + mult_state, wait MULT_LAT
//   cycles, copy mult_out into the state register. Final state returned on res_*.
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : gate_sequencer_if.slave (init_*, cmd_*, gate_sel, mult_*, res_*, busy, gate_count)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for init_valid; init_ready=1
// S_ISSUE   | pop next gate (stall here while queue empty)
// S_WAIT    | inputs held to multiplier, down-counter runs MULT_LAT cycles
// S_CAPTURE | state register <= mult_out, gate_count++
// S_DONE    | res_valid=1 until res_ready
module gate_sequencer #(
    parameter int N        = 2,
    parameter int W        = 8,
    parameter int MULT_LAT = 2,
    parameter int QDEPTH   = 8,
    parameter int GID_W    = 4
) (
    input logic             clk,
    input logic             reset,
    gate_sequencer_if.slave bus
);
    localparam int MAX   = 2 ** N;
    localparam int V     = 2 * W * MAX;
    localparam int AW    = $clog2(QDEPTH);
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [V-1:0]     state_reg;
    logic [GID_W-1:0] gate_sel_r;
    logic [V-1:0]     mult_state_r;
    logic [7:0]       gate_count_r;
    logic             last_r;
    logic [CNT_W-1:0] wait_cnt;

    // Gate-ID queue: entries are {gid, last}; pointers carry one extra wrap bit.
    logic [GID_W:0] q_mem [QDEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           q_empty, q_full, push, pop;
    logic [GID_W:0] q_head;

    logic load_init, capture;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = bus.cmd_valid && !q_full;
    assign q_head  = q_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr[AW-1:0]] <= {bus.cmd_gid, bus.cmd_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_init = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.init_valid) begin
                    load_init = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = last_r ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            state_reg    <= '0;
            gate_sel_r   <= '0;
            mult_state_r <= '0;
            gate_count_r <= '0;
            last_r       <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_init) begin
                state_reg    <= bus.init_state;
                gate_count_r <= '0;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                gate_sel_r   <= q_head[GID_W:1];
                last_r       <= q_head[0];
                mult_state_r <= state_reg;
                // WAIT spans MULT_LAT cycles: count MULT_LAT-1 down to terminal 0.
                wait_cnt     <= CNT_W'(MULT_LAT - 1);
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                state_reg <= bus.mult_out;
                if (gate_count_r != 8'hFF) begin
                    gate_count_r <= gate_count_r + 8'd1;
                end
            end
        end
    end

    assign bus.init_ready = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.res_valid  = (state == S_DONE);
    assign bus.cmd_ready  = !q_full;
    assign bus.gate_sel   = gate_sel_r;
    assign bus.mult_state = mult_state_r;
    assign bus.res_state  = state_reg;
    assign bus.gate_count = gate_count_r;
endmodule
